// File: rtl/cluster_step_sequencer_pkg.sv
// cluster_step_sequencer_pkg: shared state encoding and default sizes for the cluster step sequencer.
package cluster_step_sequencer_pkg;

    localparam int DEF_PE_NUM = 4;
    localparam int DEF_I_T = 5;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_PE_START,
        SEQ_PE_WAIT,
        SEQ_SCHE_START,
        SEQ_SCHE_WAIT,
        SEQ_STEP_NEXT,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/cluster_step_sequencer_if.sv
// cluster_step_sequencer_if: run configuration, PE/scheduler handshake and status bundle.
// slave modport is the sequencer's view; master is the controller/cluster side.
interface cluster_step_sequencer_if
    import cluster_step_sequencer_pkg::*;
#(
    parameter int PE_NUM = DEF_PE_NUM,
    parameter int I_T = DEF_I_T
) ();

    logic              cfg_start;
    logic [I_T-1:0]    cfg_timesteps;
    logic [PE_NUM-1:0] cfg_pe_mask;
    logic              abort;
    logic [PE_NUM-1:0] pe_finish;
    logic              sche_finish;
    logic [PE_NUM-1:0] pe_start;
    logic              start_sche;
    logic [I_T-1:0]    timestamp;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic [PE_NUM-1:0] pe_done_vec;

    modport slave (
        input  cfg_start, cfg_timesteps, cfg_pe_mask, abort, pe_finish, sche_finish,
        output pe_start, start_sche, timestamp, busy, done, err_timeout, pe_done_vec
    );

    modport master (
        output cfg_start, cfg_timesteps, cfg_pe_mask, abort, pe_finish, sche_finish,
        input  pe_start, start_sche, timestamp, busy, done, err_timeout, pe_done_vec
    );

endinterface

// File: rtl/cluster_step_sequencer_watchdog.sv
// seq_watchdog: wait-state cycle counter; expired flags the last allowed cycle.
// Ports: clk, rst; clr zeroes the count, en advances it; limit is the cycle budget (0 disables).
module seq_watchdog #(
    parameter int WD_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [WD_WIDTH-1:0] limit,
    output logic                expired
);

    logic [WD_WIDTH-1:0] cnt;

    always_ff @(posedge clk)
        cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;

    assign expired = en && limit != '0 && cnt == limit - 1'b1;

endmodule

// File: rtl/cluster_step_sequencer.sv
// cluster_step_sequencer: per-cluster timestep controller (launch PEs, gather finishes, run scheduler, advance).
// Ports: clk, rst (sync, active-high); bus carries config, abort, finish pulses in and start pulses/status out.
module cluster_step_sequencer
    import cluster_step_sequencer_pkg::*;
#(
    parameter int                  PE_NUM = DEF_PE_NUM,
    parameter int                  I_T = DEF_I_T,
    parameter int                  WD_WIDTH = 16,
    parameter logic [WD_WIDTH-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input logic                     clk,
    input logic                     rst,
    cluster_step_sequencer_if.slave bus
);

    seq_state_t        state;
    logic [PE_NUM-1:0] mask;
    logic [I_T-1:0]    steps;
    logic [PE_NUM-1:0] done_next;
    logic              waiting;
    logic              expired;

    assign waiting = state == SEQ_PE_WAIT || state == SEQ_SCHE_WAIT;
    // a finish arriving in the completing cycle counts immediately
    assign done_next = bus.pe_done_vec | (bus.pe_finish & mask);

    // held at zero outside the wait states, so every wait starts from a fresh count
    seq_watchdog #(.WD_WIDTH(WD_WIDTH)) u_watchdog (
        .clk(clk),
        .rst(rst),
        .clr(!waiting),
        .en(waiting),
        .limit(TIMEOUT_CYCLES),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SEQ_IDLE;
            mask            <= '0;
            steps           <= '0;
            bus.pe_start    <= '0;
            bus.start_sche  <= 1'b0;
            bus.timestamp   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.pe_done_vec <= '0;
        end else begin
            bus.pe_start   <= '0;
            bus.start_sche <= 1'b0;
            bus.done       <= 1'b0;
            if (bus.abort && state != SEQ_IDLE) begin
                state    <= SEQ_IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    SEQ_IDLE: begin
                        if (bus.cfg_start && !bus.abort && bus.cfg_timesteps != '0 && bus.cfg_pe_mask != '0) begin
                            mask            <= bus.cfg_pe_mask;
                            steps           <= bus.cfg_timesteps;
                            bus.timestamp   <= '0;
                            bus.err_timeout <= 1'b0;
                            bus.busy        <= 1'b1;
                            state           <= SEQ_PE_START;
                        end
                    end
                    SEQ_PE_START: begin
                        bus.pe_start    <= mask;
                        bus.pe_done_vec <= '0;
                        state           <= SEQ_PE_WAIT;
                    end
                    SEQ_PE_WAIT: begin
                        bus.pe_done_vec <= done_next;
                        if (done_next == mask) begin
                            state <= SEQ_SCHE_START;
                        end else if (expired) begin
                            bus.err_timeout <= 1'b1;
                            bus.busy        <= 1'b0;
                            state           <= SEQ_IDLE;
                        end
                    end
                    SEQ_SCHE_START: begin
                        bus.start_sche <= 1'b1;
                        state          <= SEQ_SCHE_WAIT;
                    end
                    SEQ_SCHE_WAIT: begin
                        if (bus.sche_finish) begin
                            state <= (bus.timestamp == steps - 1'b1) ? SEQ_DONE : SEQ_STEP_NEXT;
                        end else if (expired) begin
                            bus.err_timeout <= 1'b1;
                            bus.busy        <= 1'b0;
                            state           <= SEQ_IDLE;
                        end
                    end
                    SEQ_STEP_NEXT: begin
                        bus.timestamp <= bus.timestamp + 1'b1;
                        state         <= SEQ_PE_START;
                    end
                    SEQ_DONE: begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= SEQ_IDLE;
                    end
                    default: state <= SEQ_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cluster_step_sequencer.sv
// tb_cluster_step_sequencer: table-driven runs with a pe_start scoreboard plus watchdog, abort, illegal-config and reset sequences.
module tb_cluster_step_sequencer;

    typedef struct packed {
        logic [3:0] pe;
        logic [4:0] ts;
    } exp_t;

    typedef struct {
        logic [3:0]      mask;
        logic [4:0]      steps;
        logic [3:0][3:0] d;
        logic            stray;
        int              sche_d;
        int              abort_step;
        int              exp_done;
        logic            exp_to;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t q[$];
    exp_t e;
    vec_t vecs[6];

    always #5 clk = ~clk;

    cluster_step_sequencer_if #(.PE_NUM(4), .I_T(5)) bus ();

    cluster_step_sequencer #(
        .PE_NUM(4),
        .I_T(5),
        .WD_WIDTH(16),
        .TIMEOUT_CYCLES(16'd20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // every pe_start pulse must match the next expected {mask, timestamp}
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.pe_start != '0) begin
            if (q.size() == 0) check("sb_unexpected_pe_start", bus.pe_start, 0);
            else begin
                e = q.pop_front();
                check("sb_pe_start", bus.pe_start, e.pe);
                check("sb_timestamp", bus.timestamp, e.ts);
            end
        end
    end

    task automatic run(input vec_t v);
        int cyc;
        int maxd;
        maxd = 0;
        for (int i = 0; i < 4; i++) if (v.mask[i] && v.d[i] > maxd) maxd = v.d[i];
        q.push_back('{v.mask, 5'd0});
        bus.cfg_timesteps = v.steps;
        bus.cfg_pe_mask = v.mask;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        check("accept_busy", bus.busy, 1);
        check("accept_err_clr", bus.err_timeout, 0);
        tick();
        for (int s = 0; s < v.steps; s++) begin
            check("pe_done_clr", bus.pe_done_vec, 0);
            for (int c = 1; c <= maxd; c++) begin
                tick();
                for (int i = 0; i < 4; i++) bus.pe_finish[i] = v.mask[i] ? (v.d[i] == c) : v.stray;
                bus.sche_finish = v.stray;
            end
            cyc = maxd;
            while (!bus.start_sche && !bus.err_timeout && cyc < 40) begin
                tick();
                cyc++;
                bus.pe_finish = '0;
                bus.sche_finish = 1'b0;
            end
            if (v.exp_to) begin
                check("wd_cycles", cyc, 20);
                check("wd_busy", bus.busy, 0);
                check("wd_err", bus.err_timeout, 1);
                repeat (3) tick();
                return;
            end
            check("sche_latency", cyc, maxd + 2);
            check("pe_done_vec", bus.pe_done_vec, v.mask);
            check("step_ts", bus.timestamp, s);
            bus.pe_finish = v.stray ? 4'hF : 4'h0;
            repeat (v.sche_d - 1) tick();
            bus.pe_finish = '0;
            if (s == v.abort_step) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                check("abort_busy", bus.busy, 0);
                check("abort_ts", bus.timestamp, s);
                check("abort_start_sche", bus.start_sche, 0);
                repeat (3) tick();
                bus.cfg_start = 1'b1;
                bus.abort = 1'b1;
                tick();
                bus.cfg_start = 1'b0;
                bus.abort = 1'b0;
                check("abort_cfg_rejected", bus.busy, 0);
                tick();
                check("abort_cfg_still_idle", bus.busy, 0);
                return;
            end
            bus.sche_finish = 1'b1;
            tick();
            bus.sche_finish = 1'b0;
            check("start_sche_pulse", bus.start_sche, 0);
            check("step_busy", bus.busy, 1);
            check("step_no_done", bus.done, 0);
            if (s == v.steps - 1) begin
                tick();
                check("done_pulse", bus.done, 1);
                check("done_busy", bus.busy, 0);
                check("final_ts", bus.timestamp, v.steps - 1);
                tick();
                check("done_one_cycle", bus.done, 0);
            end else begin
                q.push_back('{v.mask, 5'(s + 1)});
                tick();
                tick();
            end
        end
    endtask

    initial begin
        int b;
        vecs[0] = '{4'hF, 5'd1, 16'h9975, 1'b0, 3, -1, 1, 1'b0};
        vecs[1] = '{4'h5, 5'd3, 16'h0402, 1'b1, 2, -1, 1, 1'b0};
        vecs[2] = '{4'hA, 5'd2, 16'h2040, 1'b1, 4, -1, 1, 1'b0};
        vecs[3] = '{4'h8, 5'd31, 16'h1000, 1'b0, 1, -1, 1, 1'b0};
        vecs[4] = '{4'hF, 5'd2, 16'h3033, 1'b0, 1, -1, 0, 1'b1};
        vecs[5] = '{4'h3, 5'd4, 16'h0032, 1'b0, 3, 1, 0, 1'b0};
        rst = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_timesteps = '0;
        bus.cfg_pe_mask = '0;
        bus.abort = 1'b0;
        bus.pe_finish = '0;
        bus.sche_finish = 1'b0;
        repeat (2) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_pe_start", bus.pe_start, 0);
        check("rst_timestamp", bus.timestamp, 0);
        check("rst_err", bus.err_timeout, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            b = done_cnt;
            run(vecs[i]);
            check("run_done_cnt", done_cnt - b, vecs[i].exp_done);
            check("run_err", bus.err_timeout, vecs[i].exp_to);
            check("run_busy_end", bus.busy, 0);
        end
        bus.cfg_timesteps = 5'd0;
        bus.cfg_pe_mask = 4'hF;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        tick();
        check("illegal_steps_busy", bus.busy, 0);
        check("illegal_ts_hold", bus.timestamp, 1);
        bus.cfg_timesteps = 5'd3;
        bus.cfg_pe_mask = 4'h0;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        tick();
        check("illegal_mask_busy", bus.busy, 0);
        q.push_back('{4'hF, 5'd0});
        bus.cfg_pe_mask = 4'hF;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        tick();
        bus.pe_finish = 4'h1;
        tick();
        bus.pe_finish = 4'h0;
        check("pre_rst_done_vec", bus.pe_done_vec, 1);
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst_busy", bus.busy, 0);
        check("midrun_rst_done_vec", bus.pe_done_vec, 0);
        check("midrun_rst_pe_start", bus.pe_start, 0);
        check("midrun_rst_start_sche", bus.start_sche, 0);
        check("midrun_rst_done", bus.done, 0);
        check("midrun_rst_err", bus.err_timeout, 0);
        check("midrun_rst_ts", bus.timestamp, 0);
        repeat (3) tick();
        check("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1);
    end

endmodule
